// File: rtl/fifo_status_monitor_pkg.sv
// fifo_status_monitor_pkg: shared defaults, threshold layout, class map and pause-state encodings
package fifo_status_monitor_pkg;
   localparam int DEPTH_DEF = 8;
   localparam int CW_DEF = 4;
   localparam int NFIFO = 5;
   localparam int NCLS = 3;
   localparam logic [3:0] THR_LO_RST = 4'd1;
   // one-hot so each state is a single flop bit
   typedef enum logic [1:0] {FLOW = 2'b01, PAUSE = 2'b10} pause_state_e;
   // matches the UMF/UVC/UD byte layout: [7:4] high, [3:0] low
   typedef struct packed {
      logic [3:0] hi;
      logic [3:0] lo;
   } thr_t;
   // FIFO0 = UMF (0), FIFO1-2 = UVC (1), FIFO3-4 = UD (2)
   function automatic int fifo_class(input int i);
      return i == 0 ? 0 : i < 3 ? 1 : 2;
   endfunction
   function automatic thr_t thr_rst(input int depth);
      return '{hi: 4'(depth - 2), lo: THR_LO_RST};
   endfunction
endpackage

// File: rtl/fifo_status_monitor_if.sv
// fifo_status_monitor_if: threshold load, push/pop strobes and status vectors of the FIFO monitor
//   master: drives thr_load/UMF/UVC/UD/push/pop/err_clr, observes status
//   slave : the monitor, drives FIFO_EMPTY/FIFO_ERROR/ovf/udf/flags/pause/cfg_err
interface fifo_status_monitor_if;
   logic       thr_load;
   logic [7:0] UMF;
   logic [7:0] UVC;
   logic [7:0] UD;
   logic [4:0] push;
   logic [4:0] pop;
   logic       err_clr;
   logic [4:0] FIFO_EMPTY;
   logic [4:0] FIFO_ERROR;
   logic [4:0] fifo_ovf;
   logic [4:0] fifo_udf;
   logic [4:0] almost_full;
   logic [4:0] almost_empty;
   logic [4:0] pause;
   logic       pause_any;
   logic       cfg_err;
   modport master (
      output thr_load, UMF, UVC, UD, push, pop, err_clr,
      input  FIFO_EMPTY, FIFO_ERROR, fifo_ovf, fifo_udf, almost_full, almost_empty, pause, pause_any, cfg_err
   );
   modport slave (
      input  thr_load, UMF, UVC, UD, push, pop, err_clr,
      output FIFO_EMPTY, FIFO_ERROR, fifo_ovf, fifo_udf, almost_full, almost_empty, pause, pause_any, cfg_err
   );
endinterface

// File: rtl/fifo_occ_tracker.sv
// fifo_occ_tracker: one FIFO's saturating occupancy counter, sticky ovf/udf, pause FSM and flags
//   in : clk, reset, push, pop, err_clr, lo/hi thresholds
//   out: empty, ovf, udf, af (almost full), ae (almost empty), pause
module fifo_occ_tracker
   import fifo_status_monitor_pkg::*;
#(
   parameter int DEPTH = DEPTH_DEF,
   parameter int CW = CW_DEF
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       push,
   input  logic       pop,
   input  logic       err_clr,
   input  logic [3:0] lo,
   input  logic [3:0] hi,
   output logic       empty,
   output logic       ovf,
   output logic       udf,
   output logic       af,
   output logic       ae,
   output logic       pause
);
   logic [CW-1:0] cnt;
   logic [CW-1:0] nxt;
   logic          full;
   logic          zero;
   logic          ge_hi;
   logic          le_lo;
   pause_state_e  st;
   assign full = cnt == CW'(DEPTH);
   assign zero = cnt == '0;
   // push+pop at empty: the pop is illegal but the push still lands
   always_comb begin
      nxt = (push && pop) ? (zero ? CW'(1) : cnt)
          : push ? (full ? cnt : cnt + 1'b1)
          : pop ? (zero ? cnt : cnt - 1'b1)
          : cnt;
      ge_hi = 32'(nxt) >= 32'(hi);
      le_lo = 32'(nxt) <= 32'(lo);
   end
   always_ff @(posedge clk) begin
      if (reset) begin
         cnt   <= '0;
         ovf   <= 1'b0;
         udf   <= 1'b0;
         st    <= FLOW;
         empty <= 1'b1;
         af    <= 1'b0;
         ae    <= 1'b1;
      end else begin
         cnt   <= nxt;
         // a new event outranks a simultaneous clear
         ovf   <= (push & ~pop & full) | (ovf & ~err_clr);
         udf   <= (pop & zero) | (udf & ~err_clr);
         st    <= st == FLOW ? (ge_hi ? PAUSE : FLOW) : (le_lo ? FLOW : PAUSE);
         empty <= nxt == '0;
         af    <= ge_hi;
         ae    <= le_lo;
      end
   end
   assign pause = st == PAUSE;
endmodule

// File: rtl/fifo_status_monitor.sv
// fifo_status_monitor: threshold registers with load validation, fan-out to five occupancy trackers
//   in : clk, reset (sync, active-high), bus (slave) carrying thresholds, strobes and err_clr
//   out: bus status vectors FIFO_EMPTY/FIFO_ERROR/fifo_ovf/fifo_udf/almost_*/pause/pause_any/cfg_err
module fifo_status_monitor
   import fifo_status_monitor_pkg::*;
#(
   parameter int DEPTH = DEPTH_DEF,
   parameter int CW = CW_DEF
) (
   input logic                 clk,
   input logic                 reset,
   fifo_status_monitor_if.slave bus
);
   thr_t            thr    [NCLS];
   thr_t            thr_in [NCLS];
   logic [NCLS-1:0] bad;
   logic            cfg_err_q;
   always_comb begin
      thr_in[0] = bus.UMF;
      thr_in[1] = bus.UVC;
      thr_in[2] = bus.UD;
      for (int c = 0; c < NCLS; c++) bad[c] = thr_in[c].lo >= thr_in[c].hi;
   end
   // each class is validated on its own; a bad class never blocks the good ones
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int c = 0; c < NCLS; c++) thr[c] <= thr_rst(DEPTH);
         cfg_err_q <= 1'b0;
      end else begin
         for (int c = 0; c < NCLS; c++) if (bus.thr_load && !bad[c]) thr[c] <= thr_in[c];
         cfg_err_q <= bus.thr_load & |bad;
      end
   end
   for (genvar i = 0; i < NFIFO; i++) begin : g_trk
      localparam int C = fifo_class(i);
      fifo_occ_tracker #(.DEPTH(DEPTH), .CW(CW)) u_trk (
         .clk     (clk),
         .reset   (reset),
         .push    (bus.push[i]),
         .pop     (bus.pop[i]),
         .err_clr (bus.err_clr),
         .lo      (thr[C].lo),
         .hi      (thr[C].hi),
         .empty   (bus.FIFO_EMPTY[i]),
         .ovf     (bus.fifo_ovf[i]),
         .udf     (bus.fifo_udf[i]),
         .af      (bus.almost_full[i]),
         .ae      (bus.almost_empty[i]),
         .pause   (bus.pause[i])
      );
   end
   // pure functions of flops, so they stay aligned with their source bits
   assign bus.FIFO_ERROR = bus.fifo_ovf | bus.fifo_udf;
   assign bus.pause_any  = |bus.pause;
   assign bus.cfg_err    = cfg_err_q;
endmodule
